// File: rtl/sdr_arb_pkg.sv
// Shared types for the SDRAM port arbiter: FSM states, burst owner and direction.
package sdr_arb_pkg;

    localparam int ADDR_W = 12;
    localparam int DATA_W = 16;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        BURST_C,
        BURST_V,
        GAPW
    } state_t;

    typedef enum logic {
        OWN_C,
        OWN_V
    } owner_t;

    typedef enum logic {
        DIR_RD,
        DIR_WR
    } dir_t;

endpackage

// File: rtl/sdr_arb_beatcnt.sv
// Beat counter plus stuck-burst watchdog for one controller transaction.
module sdr_arb_beatcnt #(
    parameter int BURST   = 16,
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic strobe,
    input  logic clear,
    input  logic enable,
    output logic done,
    output logic timeout
);
    localparam int BW = $clog2(BURST + 1);
    localparam int WW = $clog2(TIMEOUT + 1);

    logic [BW-1:0] beat;
    logic [WW-1:0] wd;

    always_ff @(posedge clk) begin
        if (!rst || clear) begin
            beat <= '0;
            wd   <= '0;
        end else if (enable) begin
            if (strobe) begin
                beat <= beat + 1'b1;
                wd   <= '0;
            end else begin
                wd <= wd + 1'b1;
            end
        end
    end

    // Both fire on the edge that completes the condition, so the FSM leaves the burst there.
    assign done    = enable & strobe & (beat == BW'(BURST - 1));
    assign timeout = enable & ~strobe & (wd == WW'(TIMEOUT - 1));

endmodule

// File: rtl/sdr_port_arbiter.sv
// Shares the SDRAM controller burst port between the cache (read/write) and the
// video line fetcher (read only), with bounded video priority and a burst watchdog.
module sdr_port_arbiter
    import sdr_arb_pkg::*;
#(
    parameter int BURST   = 16,
    parameter int GAP     = 2,
    parameter int VMAX    = 4,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] c_addr,
    input  logic              c_rd,
    input  logic              c_wr,
    output logic              c_ack,
    input  logic [DATA_W-1:0] c_din,
    output logic              c_get,
    output logic              c_put,
    input  logic [ADDR_W-1:0] v_addr,
    input  logic              v_rd,
    output logic              v_ack,
    output logic              v_put,
    output logic [ADDR_W-1:0] m_addr,
    output logic              m_rd,
    output logic              m_wr,
    output logic [DATA_W-1:0] m_din,
    input  logic              m_get,
    input  logic              m_put,
    input  logic [DATA_W-1:0] m_dout,
    output logic              err
);
    localparam int VW = $clog2(VMAX + 1);
    localparam int GW = $clog2(GAP + 2);
    localparam logic [GW-1:0] GAP_LAST = GW'((GAP > 0) ? GAP - 1 : 0);

    state_t        state, next;
    owner_t        owner;
    dir_t          dir;
    logic [VW-1:0] vcnt;
    logic [GW-1:0] gcnt;
    logic          cache_req, pick_v, in_burst, cache_wr_burst, strobe;
    logic          bc_done, bc_timeout, gap_done;
    logic          m_dout_unused;

    // Requesters tap m_dout directly; only the strobes are qualified here.
    assign m_dout_unused  = ^m_dout;

    assign cache_req      = c_rd | c_wr;
    assign pick_v         = v_rd & ~(cache_req & (vcnt == VW'(VMAX)));
    assign in_burst       = (state == BURST_C) || (state == BURST_V);
    assign cache_wr_burst = (state == BURST_C) && (dir == DIR_WR);
    assign strobe         = cache_wr_burst ? m_get : m_put;
    assign gap_done       = (gcnt == GAP_LAST);

    sdr_arb_beatcnt #(
        .BURST  (BURST),
        .TIMEOUT(TIMEOUT)
    ) u_beatcnt (
        .clk    (clk),
        .rst    (rst),
        .strobe (strobe),
        .clear  (state == ISSUE),
        .enable (in_burst),
        .done   (bc_done),
        .timeout(bc_timeout)
    );

    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= next;
    end

    always_comb begin
        next = state;
        case (state)
            IDLE:            if (cache_req || v_rd) next = ISSUE;
            ISSUE:           next = (owner == OWN_C) ? BURST_C : BURST_V;
            BURST_C,
            BURST_V:         if (bc_done || bc_timeout) next = GAPW;
            GAPW:            if (gap_done) next = IDLE;
            default:         next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            owner  <= OWN_C;
            dir    <= DIR_RD;
            m_addr <= '0;
            vcnt   <= '0;
            gcnt   <= '0;
            err    <= 1'b0;
        end else begin
            if (state == IDLE && (cache_req || v_rd)) begin
                owner  <= pick_v ? OWN_V : OWN_C;
                dir    <= (!pick_v && c_wr) ? DIR_WR : DIR_RD;
                m_addr <= pick_v ? v_addr : c_addr;
                // Video streak only grows while the cache is actually waiting.
                if (pick_v && cache_req)
                    vcnt <= (vcnt == VW'(VMAX)) ? vcnt : vcnt + 1'b1;
                else
                    vcnt <= '0;
            end
            gcnt <= (state == GAPW) ? gcnt + 1'b1 : '0;
            if (bc_timeout) err <= 1'b1;
        end
    end

    always_comb begin
        c_ack = (state == ISSUE) && (owner == OWN_C);
        v_ack = (state == ISSUE) && (owner == OWN_V);
        m_rd  = (state == ISSUE) && (dir == DIR_RD);
        m_wr  = (state == ISSUE) && (dir == DIR_WR);
        c_put = (state == BURST_C) && (dir == DIR_RD) && m_put;
        c_get = cache_wr_burst && m_get;
        v_put = (state == BURST_V) && m_put;
        m_din = cache_wr_burst ? c_din : '0;
    end

endmodule

// File: tb/tb_sdr_port_arbiter.sv
// Self-checking bench for sdr_port_arbiter: directed scenarios plus a randomized
// request mix checked against a grant/beat model kept in the bench.
module tb_sdr_port_arbiter;
    localparam int BURST   = 16;
    localparam int GAP     = 2;
    localparam int VMAX    = 4;
    localparam int TIMEOUT = 255;

    logic        clk = 1'b0;
    logic        rst;
    logic [11:0] c_addr, v_addr, m_addr;
    logic        c_rd, c_wr, c_ack, c_get, c_put;
    logic [15:0] c_din, m_din, m_dout;
    logic        v_rd, v_ack, v_put;
    logic        m_rd, m_wr, m_get, m_put, err;

    int total = 0;
    int bad   = 0;

    sdr_port_arbiter #(
        .BURST  (BURST),
        .GAP    (GAP),
        .VMAX   (VMAX),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst),
        .c_addr(c_addr), .c_rd(c_rd), .c_wr(c_wr), .c_ack(c_ack), .c_din(c_din),
        .c_get(c_get), .c_put(c_put),
        .v_addr(v_addr), .v_rd(v_rd), .v_ack(v_ack), .v_put(v_put),
        .m_addr(m_addr), .m_rd(m_rd), .m_wr(m_wr), .m_din(m_din),
        .m_get(m_get), .m_put(m_put), .m_dout(m_dout), .err(err)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wait_ack(output int ticks);
        ticks = 0;
        do begin
            tick();
            ticks++;
        end while (!(c_ack === 1'b1 || v_ack === 1'b1) && ticks < 20);
    endtask

    // Plays the controller for one burst and tallies what the DUT routed.
    task automatic drive_burst(input int nbeats, input bit cnt_get, input int stray_mode,
                               input bit din_follows, output int n_cput, output int n_vput,
                               output int n_cget, output int n_din_bad);
        int          idle;
        bit          beat, stray;
        logic [15:0] din_exp;
        n_cput = 0; n_vput = 0; n_cget = 0; n_din_bad = 0;
        tick();
        for (int b = 0; b < nbeats; b++) begin
            idle = (stray_mode == 2) ? 1 : ((stray_mode == 1) ? int'($urandom_range(0, 2)) : 0);
            for (int i = 0; i <= idle; i++) begin
                beat   = (i == idle);
                stray  = !beat && (stray_mode == 2 || (stray_mode == 1 && $urandom_range(0, 1) == 1));
                m_put  = cnt_get ? stray : beat;
                m_get  = cnt_get ? beat : stray;
                c_din  = 16'($urandom);
                m_dout = 16'($urandom);
                din_exp = din_follows ? c_din : 16'h0;
                #1;
                if (c_put === 1'b1) n_cput++;
                if (v_put === 1'b1) n_vput++;
                if (c_get === 1'b1) n_cget++;
                if (m_din !== din_exp) n_din_bad++;
                tick();
            end
        end
        m_put = 1'b0;
        m_get = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        tick();
        tick();
        total++;
        if ({c_ack, c_get, c_put, v_ack, v_put, m_rd, m_wr, err, m_addr, m_din} !== 36'h0) begin
            bad++;
            $display("FAIL reset_outputs: got %h want 0",
                     {c_ack, c_get, c_put, v_ack, v_put, m_rd, m_wr, err, m_addr, m_din});
        end
        rst = 1'b1;
        tick();
        total++;
        if ({c_ack, v_ack, m_rd, m_wr, err} !== 5'h0) begin
            bad++;
            $display("FAIL idle_no_request: got %b want 00000", {c_ack, v_ack, m_rd, m_wr, err});
        end
    endtask

    task automatic test_cache_read();
        int t, nc, nv, ng, nd;
        c_addr = 12'h123;
        c_rd   = 1'b1;
        wait_ack(t);
        total++;
        if (t != 1 || {c_ack, v_ack, m_rd, m_wr} !== 4'b1010 || m_addr !== 12'h123) begin
            bad++;
            $display("FAIL cread_issue: got t=%0d ack/rw=%b addr=%h want t=1 1010 123",
                     t, {c_ack, v_ack, m_rd, m_wr}, m_addr);
        end
        c_rd = 1'b0;
        drive_burst(BURST, 1'b0, 0, 1'b0, nc, nv, ng, nd);
        total++;
        if (nc != BURST || nv != 0 || ng != 0 || nd != 0) begin
            bad++;
            $display("FAIL cread_routing: got cput=%0d vput=%0d cget=%0d din_bad=%0d want %0d 0 0 0",
                     nc, nv, ng, nd, BURST);
        end
        total++;
        if (m_addr !== 12'h123) begin
            bad++;
            $display("FAIL maddr_hold: got %h want 123", m_addr);
        end
        c_addr = 12'h456;
        c_rd   = 1'b1;
        wait_ack(t);
        total++;
        if (t != GAP + 1 || c_ack !== 1'b1 || m_addr !== 12'h456) begin
            bad++;
            $display("FAIL cread_gap: got t=%0d ack=%b addr=%h want t=%0d 1 456", t, c_ack, m_addr, GAP + 1);
        end
        c_rd = 1'b0;
        drive_burst(BURST, 1'b0, 0, 1'b0, nc, nv, ng, nd);
    endtask

    task automatic test_cache_write();
        int t, nc, nv, ng, nd;
        c_addr = 12'h2A5;
        c_rd   = 1'b1;
        c_wr   = 1'b1;
        wait_ack(t);
        total++;
        if (t != GAP + 1 || {c_ack, v_ack, m_rd, m_wr} !== 4'b1001 || m_addr !== 12'h2A5) begin
            bad++;
            $display("FAIL cwrite_issue: got t=%0d ack/rw=%b addr=%h want t=%0d 1001 2a5",
                     t, {c_ack, v_ack, m_rd, m_wr}, m_addr, GAP + 1);
        end
        c_rd = 1'b0;
        c_wr = 1'b0;
        drive_burst(BURST, 1'b1, 0, 1'b1, nc, nv, ng, nd);
        total++;
        if (nc != 0 || nv != 0 || ng != BURST || nd != 0) begin
            bad++;
            $display("FAIL cwrite_routing: got cput=%0d vput=%0d cget=%0d din_bad=%0d want 0 0 %0d 0",
                     nc, nv, ng, nd, BURST);
        end
    endtask

    task automatic test_stray();
        int t, nc, nv, ng, nd;
        c_addr = 12'h0F0;
        c_rd   = 1'b1;
        wait_ack(t);
        c_rd = 1'b0;
        drive_burst(BURST, 1'b0, 2, 1'b0, nc, nv, ng, nd);
        total++;
        if (nc != BURST || nv != 0 || ng != 0 || nd != 0) begin
            bad++;
            $display("FAIL stray_cread: got cput=%0d vput=%0d cget=%0d din_bad=%0d want %0d 0 0 0",
                     nc, nv, ng, nd, BURST);
        end
        v_addr = 12'h777;
        v_rd   = 1'b1;
        wait_ack(t);
        total++;
        if (t != GAP + 1 || {c_ack, v_ack, m_rd, m_wr} !== 4'b0110 || m_addr !== 12'h777) begin
            bad++;
            $display("FAIL stray_end: got t=%0d ack/rw=%b addr=%h want t=%0d 0110 777",
                     t, {c_ack, v_ack, m_rd, m_wr}, m_addr, GAP + 1);
        end
        v_rd = 1'b0;
        drive_burst(BURST, 1'b0, 2, 1'b0, nc, nv, ng, nd);
        total++;
        if (nc != 0 || nv != BURST || ng != 0 || nd != 0) begin
            bad++;
            $display("FAIL stray_vread: got cput=%0d vput=%0d cget=%0d din_bad=%0d want 0 %0d 0 0",
                     nc, nv, ng, nd, BURST);
        end
    endtask

    task automatic test_fairness();
        int         t, nc, nv, ng, nd;
        logic [9:0] got, expv;
        logic [5:0] gotv;
        v_addr = 12'h0E1;
        c_addr = 12'h0C1;
        v_rd   = 1'b1;
        c_rd   = 1'b1;
        for (int g = 0; g < 10; g++) begin
            wait_ack(t);
            got[g]  = (v_ack === 1'b1 && c_ack === 1'b0);
            expv[g] = ((g % 5) != 4);
            if (g == 9) c_rd = 1'b0;
            drive_burst(BURST, 1'b0, 0, 1'b0, nc, nv, ng, nd);
        end
        total++;
        if (got !== expv) begin
            bad++;
            $display("FAIL fairness_seq: got %b want %b (bit=1 means video, bit0 first)", got, expv);
        end
        for (int g = 0; g < 6; g++) begin
            wait_ack(t);
            gotv[g] = (v_ack === 1'b1 && c_ack === 1'b0);
            if (g == 5) v_rd = 1'b0;
            drive_burst(BURST, 1'b0, 0, 1'b0, nc, nv, ng, nd);
        end
        total++;
        if (gotv !== 6'h3F) begin
            bad++;
            $display("FAIL video_only: got %b want 111111", gotv);
        end
    endtask

    task automatic test_random();
        bit          c_pend, v_pend, pick_v, cw;
        int          c_kind, streak, t, nc, nv, ng, nd;
        logic [11:0] ca, va;
        logic [15:0] got, want;
        c_pend = 1'b0; v_pend = 1'b0; streak = 0; c_kind = 1; ca = '0; va = '0;
        for (int n = 0; n < 40; n++) begin
            if (!c_pend && $urandom_range(0, 1) == 1) begin
                c_pend = 1'b1; c_kind = int'($urandom_range(1, 3)); ca = 12'($urandom);
            end
            if (!v_pend && $urandom_range(0, 2) != 0) begin
                v_pend = 1'b1; va = 12'($urandom);
            end
            if (!c_pend && !v_pend) begin
                v_pend = 1'b1; va = 12'($urandom);
            end
            c_rd = c_pend && (c_kind == 1 || c_kind == 3);
            c_wr = c_pend && (c_kind >= 2);
            c_addr = ca;
            v_rd = v_pend;
            v_addr = va;
            // Video wins unless the cache has already waited out VMAX video grants.
            pick_v = v_pend && !(c_pend && streak == VMAX);
            streak = (pick_v && c_pend) ? ((streak < VMAX) ? streak + 1 : VMAX) : 0;
            cw = !pick_v && (c_kind >= 2);
            want = {pick_v ? 2'b01 : 2'b10, cw ? 2'b01 : 2'b10, pick_v ? va : ca};
            wait_ack(t);
            got = {c_ack, v_ack, m_rd, m_wr, m_addr};
            total++;
            if (got !== want || t != GAP + 1) begin
                bad++;
                $display("FAIL rand_grant[%0d]: got ack/rw/addr=%h t=%0d want %h t=%0d", n, got, t, want, GAP + 1);
            end
            if (pick_v) v_pend = 1'b0;
            else        c_pend = 1'b0;
            v_rd = v_pend;
            c_rd = c_pend && (c_kind == 1 || c_kind == 3);
            c_wr = c_pend && (c_kind >= 2);
            drive_burst(BURST, cw, 1, cw, nc, nv, ng, nd);
            total++;
            if (nc != ((!pick_v && !cw) ? BURST : 0) || nv != (pick_v ? BURST : 0) ||
                ng != (cw ? BURST : 0) || nd != 0) begin
                bad++;
                $display("FAIL rand_routing[%0d]: got cput=%0d vput=%0d cget=%0d din_bad=%0d (video=%0d write=%0d)",
                         n, nc, nv, ng, nd, pick_v, cw);
            end
        end
        c_rd = 1'b0;
        c_wr = 1'b0;
        v_rd = 1'b0;
    endtask

    task automatic test_timeout();
        int t, nc, nv, ng, nd;
        v_addr = 12'h3C3;
        v_rd   = 1'b1;
        wait_ack(t);
        v_rd = 1'b0;
        drive_burst(10, 1'b0, 1, 1'b0, nc, nv, ng, nd);
        for (int k = 1; k <= TIMEOUT; k++) begin
            tick();
            if (k == TIMEOUT - 1) begin
                total++;
                if (err !== 1'b0) begin
                    bad++;
                    $display("FAIL timeout_early: got err=%b want 0 at %0d cycles", err, k);
                end
            end
            if (k == TIMEOUT) begin
                total++;
                if (err !== 1'b1) begin
                    bad++;
                    $display("FAIL timeout_set: got err=%b want 1 at %0d cycles", err, k);
                end
            end
        end
        c_addr = 12'h111;
        c_rd   = 1'b1;
        wait_ack(t);
        total++;
        if (t != GAP + 1 || c_ack !== 1'b1 || m_rd !== 1'b1 || m_addr !== 12'h111 || err !== 1'b1) begin
            bad++;
            $display("FAIL timeout_recover: got t=%0d ack=%b rd=%b addr=%h err=%b want t=%0d 1 1 111 1",
                     t, c_ack, m_rd, m_addr, err, GAP + 1);
        end
        c_rd = 1'b0;
        drive_burst(BURST, 1'b0, 0, 1'b0, nc, nv, ng, nd);
        total++;
        if (nc != BURST || err !== 1'b1) begin
            bad++;
            $display("FAIL err_sticky: got cput=%0d err=%b want %0d 1", nc, err, BURST);
        end
    endtask

    task automatic test_reset_mid_burst();
        int t, nc, nv, ng, nd;
        v_addr = 12'h5A5;
        v_rd   = 1'b1;
        wait_ack(t);
        v_rd = 1'b0;
        drive_burst(7, 1'b0, 0, 1'b0, nc, nv, ng, nd);
        rst   = 1'b0;
        m_put = 1'b1;
        tick();
        #1;
        total++;
        if ({c_ack, c_get, c_put, v_ack, v_put, m_rd, m_wr, err, m_addr, m_din} !== 36'h0) begin
            bad++;
            $display("FAIL reset_mid_burst: got %h want 0",
                     {c_ack, c_get, c_put, v_ack, v_put, m_rd, m_wr, err, m_addr, m_din});
        end
        rst   = 1'b1;
        m_put = 1'b0;
        @(negedge clk);
        c_addr = 12'h0AB;
        c_rd   = 1'b1;
        wait_ack(t);
        total++;
        if (t != 1 || {c_ack, v_ack, m_rd, m_wr} !== 4'b1010 || m_addr !== 12'h0AB) begin
            bad++;
            $display("FAIL after_reset_issue: got t=%0d ack/rw=%b addr=%h want t=1 1010 0ab",
                     t, {c_ack, v_ack, m_rd, m_wr}, m_addr);
        end
        c_rd = 1'b0;
        drive_burst(BURST, 1'b0, 0, 1'b0, nc, nv, ng, nd);
        total++;
        if (nc != BURST || nv != 0) begin
            bad++;
            $display("FAIL after_reset_burst: got cput=%0d vput=%0d want %0d 0", nc, nv, BURST);
        end
    endtask

    initial begin
        rst = 1'b0;
        c_addr = '0; c_rd = 1'b0; c_wr = 1'b0; c_din = '0;
        v_addr = '0; v_rd = 1'b0;
        m_get = 1'b0; m_put = 1'b0; m_dout = '0;
        @(negedge clk);
        test_reset();
        test_cache_read();
        test_cache_write();
        test_stray();
        test_fairness();
        test_random();
        test_timeout();
        test_reset_mid_burst();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
